// File: rtl/threshold_monitor.sv
// Debounces a stream of comparator flag triples into a confirmed relation state,
// raising a sticky alarm on entry to HIGH and counting confirmed transitions.
module threshold_monitor #(
    parameter int CONFIRM = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             lower,
    input  logic             equal,
    input  logic             greater,
    input  logic             alarm_ack,
    output logic             in_ready,
    output logic [1:0]       state,
    output logic             alarm,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_LOW     = 2'b01,
        ST_EQ      = 2'b10,
        ST_HIGH    = 2'b11
    } rel_t;

    localparam logic [3:0]       CONFIRM_L = 4'(CONFIRM);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    rel_t             state_q, state_d;
    rel_t             cand_q, cand_d;
    logic [3:0]       run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alarm_q, alarm_d;
    logic             err_q, err_d;

    rel_t             code;
    logic             code_legal;
    logic             accept;

    always_comb begin
        code       = ST_UNKNOWN;
        code_legal = 1'b1;
        case ({lower, equal, greater})
            3'b100:  code = ST_LOW;
            3'b010:  code = ST_EQ;
            3'b001:  code = ST_HIGH;
            default: code_legal = 1'b0;
        endcase
    end

    assign in_ready = ~alarm_q & ~clr;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        err_d   = err_q;
        if (clr) begin
            state_d = ST_UNKNOWN;
            cand_d  = ST_UNKNOWN;
            run_d   = 4'd0;
            cnt_d   = '0;
            alarm_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (alarm_ack)
                alarm_d = 1'b0;
            if (accept) begin
                if (!code_legal) begin
                    err_d = 1'b1;
                end else begin
                    if (code == cand_q) begin
                        run_d = (run_q >= CONFIRM_L) ? CONFIRM_L : run_q + 4'd1;
                    end else begin
                        cand_d = code;
                        run_d  = 4'd1;
                    end
                    // Alarm set is evaluated after the ack so a same-edge set wins.
                    if (run_d == CONFIRM_L && code != state_q) begin
                        state_d = code;
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + 1'b1;
                        if (code == ST_HIGH)
                            alarm_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNKNOWN;
            cand_q  <= ST_UNKNOWN;
            run_q   <= 4'd0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            err_q   <= err_d;
        end
    end

    assign state     = state_q;
    assign alarm     = alarm_q;
    assign cross_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor: a vector table for the main flow plus
// hand-written sequences for saturation, clear, mid-run reset and CONFIRM=1.
module tb_threshold_monitor;

    localparam logic [2:0] L = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] H = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] flg = 3'b000;
    logic       alarm_ack = 1'b0;

    logic       in_ready, alarm, err;
    logic [1:0] state;
    logic [7:0] cross_cnt;
    logic       in_ready1, alarm1, err1;
    logic [1:0] state1;
    logic [7:0] cross_cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    threshold_monitor #(.CONFIRM(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .lower(flg[2]), .equal(flg[1]), .greater(flg[0]), .alarm_ack(alarm_ack),
        .in_ready(in_ready), .state(state), .alarm(alarm),
        .cross_cnt(cross_cnt), .err(err)
    );

    threshold_monitor #(.CONFIRM(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .lower(flg[2]), .equal(flg[1]), .greater(flg[0]), .alarm_ack(alarm_ack),
        .in_ready(in_ready1), .state(state1), .alarm(alarm1),
        .cross_cnt(cross_cnt1), .err(err1)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [2:0] flg;
        logic       ack;
        logic [1:0] st;
        logic       al;
        logic [7:0] cnt;
        logic       er;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic c, logic vl, logic [2:0] f, logic a,
                               logic [1:0] s, logic al, logic [7:0] n,
                               logic e, logic r);
        vec_t t;
        t.clr = c; t.vld = vl; t.flg = f; t.ack = a;
        t.st = s; t.al = al; t.cnt = n; t.er = e; t.rdy = r;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, then return inputs to idle.
    task automatic step(logic c, logic vl, logic [2:0] f, logic a);
        @(negedge clk);
        clr = c; in_valid = vl; flg = f; alarm_ack = a;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; flg = 3'b000; alarm_ack = 1'b0;
        #1;
    endtask

    task automatic chk_all(string tag, logic [1:0] s, logic al, logic [7:0] n,
                           logic e, logic r);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".alarm"}, 32'(alarm), 32'(al));
        chk({tag, ".cross_cnt"}, 32'(cross_cnt), 32'(n));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(r));
    endtask

    initial begin
        vecs.push_back(v(0,1,L,0, 2'd0,0,8'd0,0,1));
        vecs.push_back(v(0,1,L,0, 2'd0,0,8'd0,0,1));
        vecs.push_back(v(0,1,L,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,H,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,H,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,E,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,H,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,H,0, 2'd1,0,8'd1,0,1));
        vecs.push_back(v(0,1,H,0, 2'd3,1,8'd2,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0,1,L,0, 2'd3,1,8'd2,0,0));
        vecs.push_back(v(0,1,L,1, 2'd3,0,8'd2,0,1));
        vecs.push_back(v(0,1,3'b110,0, 2'd3,0,8'd2,1,1));
        vecs.push_back(v(0,1,3'b000,0, 2'd3,0,8'd2,1,1));
        vecs.push_back(v(0,1,L,0, 2'd3,0,8'd2,1,1));
        vecs.push_back(v(0,1,L,0, 2'd3,0,8'd2,1,1));
        vecs.push_back(v(0,1,L,0, 2'd1,0,8'd3,1,1));
        vecs.push_back(v(0,1,E,0, 2'd1,0,8'd3,1,1));
        vecs.push_back(v(0,0,E,0, 2'd1,0,8'd3,1,1));
        vecs.push_back(v(0,1,E,0, 2'd1,0,8'd3,1,1));
        vecs.push_back(v(0,0,E,0, 2'd1,0,8'd3,1,1));
        vecs.push_back(v(0,1,E,0, 2'd2,0,8'd4,1,1));
        vecs.push_back(v(0,1,E,0, 2'd2,0,8'd4,1,1));
        vecs.push_back(v(0,1,H,0, 2'd2,0,8'd4,1,1));
        vecs.push_back(v(0,1,H,0, 2'd2,0,8'd4,1,1));
        vecs.push_back(v(0,1,H,1, 2'd3,1,8'd5,1,0));
        vecs.push_back(v(0,0,3'b000,1, 2'd3,0,8'd5,1,1));
        vecs.push_back(v(0,1,L,0, 2'd3,0,8'd5,1,1));
        vecs.push_back(v(0,1,L,0, 2'd3,0,8'd5,1,1));
        vecs.push_back(v(1,1,L,0, 2'd0,0,8'd0,0,1));
        vecs.push_back(v(0,1,L,0, 2'd0,0,8'd0,0,1));
        vecs.push_back(v(0,1,L,0, 2'd0,0,8'd0,0,1));
        vecs.push_back(v(0,1,L,0, 2'd1,0,8'd1,0,1));

        // Reset values must appear without any clock edge.
        #2;
        chk_all("reset", 2'd0, 0, 8'd0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].flg, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].al,
                    vecs[i].cnt, vecs[i].er, vecs[i].rdy);
            $display("[TB] vec %0d flags=%b vld=%0b clr=%0b ack=%0b -> state=%0d cnt=%0d alarm=%0b err=%0b",
                     i, vecs[i].flg, vecs[i].vld, vecs[i].clr, vecs[i].ack,
                     state, cross_cnt, alarm, err);
        end

        // Saturation: state is LOW with count 1; alternate EQ/LOW confirmations.
        for (int i = 0; i < 259; i++) begin
            for (int k = 0; k < 3; k++)
                step(0, 1, (i % 2 == 0) ? E : L, 0);
            if (i == 252)
                chk("sat.pre", 32'(cross_cnt), 32'd254);
        end
        chk("sat.cnt", 32'(cross_cnt), 32'd255);
        chk("sat.state", 32'(state), 32'd2);
        $display("[TB] saturation -> cnt=%0d state=%0d", cross_cnt, state);

        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; flg = L;
        #1;
        chk("clr.ready_comb", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; flg = 3'b000;
        #1;
        chk_all("clr", 2'd0, 0, 8'd0, 0, 1);
        $display("[TB] clear -> state=%0d cnt=%0d", state, cross_cnt);

        for (int k = 0; k < 3; k++) step(0, 1, L, 0);
        chk("pre_rst.state", 32'(state), 32'd1);
        step(0, 1, E, 0);
        step(0, 1, E, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 2'd0, 0, 8'd0, 0, 1);
        $display("[TB] mid-run reset -> state=%0d cnt=%0d", state, cross_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, E, 0);
        chk("rst.eq1", 32'(state), 32'd0);
        step(0, 1, E, 0);
        chk("rst.eq2", 32'(state), 32'd0);
        step(0, 1, E, 0);
        chk("rst.eq3.state", 32'(state), 32'd2);
        chk("rst.eq3.cnt", 32'(cross_cnt), 32'd1);
        $display("[TB] post-reset EQ x3 -> state=%0d cnt=%0d", state, cross_cnt);

        // CONFIRM=1 instance: every differing legal sample changes state at once.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, L, 0);
        chk("c1.low.state", 32'(state1), 32'd1);
        chk("c1.low.cnt", 32'(cross_cnt1), 32'd1);
        step(0, 1, E, 0);
        chk("c1.eq.state", 32'(state1), 32'd2);
        chk("c1.eq.cnt", 32'(cross_cnt1), 32'd2);
        step(0, 1, E, 0);
        chk("c1.eq2.cnt", 32'(cross_cnt1), 32'd2);
        step(0, 1, H, 0);
        chk("c1.high.state", 32'(state1), 32'd3);
        chk("c1.high.alarm", 32'(alarm1), 32'd1);
        chk("c1.high.ready", 32'(in_ready1), 32'd0);
        chk("c1.err", 32'(err1), 32'd0);
        chk("c3.state_after_l_e_e_h", 32'(state), 32'd0);
        $display("[TB] confirm1 -> state=%0d cnt=%0d alarm=%0b", state1, cross_cnt1, alarm1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/threshold_monitor.md
THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

Interface
REQ-001 Parameter CONFIRM, default 3: number of consecutive identical accepted samples required to change state; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of the transition counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of all internal state.
REQ-006 in_valid  input  1  the comparator flag triple is valid this cycle.
REQ-007 lower  input  1  upstream 4-bit comparator result a<b.
REQ-008 equal  input  1  upstream 4-bit comparator result a==b.
REQ-009 greater  input  1  upstream 4-bit comparator result a>b.
REQ-010 in_ready  output  1  the block accepts a sample this cycle.
REQ-011 state  output  2  confirmed relation: 00 UNKNOWN, 01 LOW, 10 EQ, 11 HIGH.
REQ-012 alarm  output  1  sticky flag, set on entry to HIGH.
REQ-013 alarm_ack  input  1  clears alarm.
REQ-014 cross_cnt  output  CNT_W  count of confirmed state transitions, saturating.
REQ-015 err  output  1  sticky flag for an illegal flag encoding.

Function
REQ-016 A sample SHALL be accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL equal ~alarm & ~clr (combinational).
- Backpressure applies while an alarm is pending.
REQ-018 Sample code SHALL be decoded from the flag triple:
- {lower,equal,greater} = 100 -> LOW; 010 -> EQ; 001 -> HIGH.
- Any other pattern is illegal.
REQ-019 An accepted illegal sample SHALL set err and SHALL NOT modify the candidate, run count, state, or cross_cnt.
REQ-020 Internal registers: candidate (2 bits) and run (4 bits).
- Accepted legal code equal to candidate: run <= min(run+1, CONFIRM).
- Otherwise: candidate <= code, run <= 1.
REQ-021 Confirmation SHALL occur on the edge where the updated run value equals CONFIRM.
- If the code differs from state at that edge, state <= code on that same edge.
- state is therefore visible the cycle after the CONFIRM-th consecutive sample is accepted: latency of 1 cycle from the final confirming sample.
REQ-022 Each confirmed change of state SHALL increment cross_cnt by 1, saturating at 2^CNT_W-1.
- The initial UNKNOWN->X change counts as a transition.
REQ-023 Confirming a code equal to the current state SHALL NOT change state, cross_cnt, or alarm.
REQ-024 alarm SHALL be set on the edge where state changes to HIGH, and cleared on an edge with alarm_ack=1.
- If a set and an ack occur on the same edge, the set wins.
REQ-025 Since in_ready=0 while alarm=1, no samples SHALL be accepted until alarm is cleared; in_valid is ignored during that time.
REQ-026 Cycles with in_valid=0 SHALL NOT break a run; run counts accepted samples, not cycles.
REQ-027 clr=1 SHALL, on the next edge, clear the following and drop any sample presented that cycle:
- state = UNKNOWN, candidate = 00, run = 0
- cross_cnt = 0, alarm = 0, err = 0
- clr has priority over alarm_ack and any sample.
REQ-028 With CONFIRM=1, every accepted legal sample whose code differs from state SHALL change state on its own edge.

Reset
REQ-029 While rst_n=0, asynchronously and without a clock edge:
- state = 00, candidate = 00, run = 0
- cross_cnt = 0, alarm = 0, err = 0
- in_ready = 1
REQ-030 A reset asserted mid-run SHALL discard partial runs; counting SHALL restart from zero after rst_n deasserts.
REQ-031 The first edge after rst_n rises SHALL be able to accept a sample.

Verification
REQ-032 CONFIRM=3; accept LOW, LOW, LOW on consecutive cycles -> state=01 in the cycle after the third sample, cross_cnt=1, alarm=0.
REQ-033 From LOW, accept HIGH, HIGH, EQ, HIGH, HIGH, HIGH.
- state stays 01 until the sixth sample; then state=11, alarm=1, cross_cnt=2, in_ready=0.
- Hold alarm_ack=0 for 5 cycles with in_valid=1: no acceptance, state unchanged.
- Pulse alarm_ack: alarm=0 and in_ready=1 next cycle.
REQ-034 Accept flags 110, then 000 -> err=1, run and state unchanged.
- A following LOW,LOW,LOW still confirms LOW after exactly 3 samples.
REQ-035 Drive 260 alternating confirmed transitions with CNT_W=8 -> cross_cnt saturates at 255.
- Assert clr -> all outputs return to reset values next cycle.
REQ-036 Accept EQ, EQ, then assert rst_n=0 mid-cycle -> state=00, cross_cnt=0 immediately.
- After release, accept one EQ: state still 00.
- Accept two more EQ: state=10.
REQ-037 Same edge carries alarm_ack=1 and a confirming third HIGH (alarm previously 0) -> alarm=1.
- Same edge carries clr=1 and a confirming sample -> state=00, cross_cnt=0.
